// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs RV32I instruction fields into 32-bit machine words and buffers them,
//   each tagged with its instruction-memory byte address, in a 2-entry FIFO.
//   Opcodes outside the supported set are accepted and dropped. They raise a
//   sticky error flag and bump a saturating error counter.
//
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   flush           : synchronous clear of FIFO, address counter and error state
//   in_valid/ready  : input handshake for one field set
//   opcode..imm     : instruction fields, sampled only on acceptance
//   out_valid/ready : output handshake for the FIFO head
//   instruction     : encoded word at the FIFO head
//   addr            : byte address of the FIFO head word
//   err, err_cnt    : sticky illegal-opcode flag and saturating illegal count
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instruction,
  output logic [31:0] addr,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0] inst_mem [2];
  logic [31:0] addr_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [31:0] pc;
  logic        err_q;
  logic [7:0]  err_cnt_q;

  logic [31:0] enc_word;
  logic        legal;
  logic        accept;
  logic        push;
  logic        pop;

  // Field packing per instruction format. Shift-immediates (slli/srli/srai)
  // carry funct7 in the upper bits instead of imm[11:5].
  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (opcode)
      OP_R:
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      OP_LOAD, OP_JALR, OP_SYSTEM:
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      OP_IMM:
        if (funct3 == 3'b001 || funct3 == 3'b101)
          enc_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        else
          enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      OP_STORE:
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      OP_BRANCH:
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      OP_LUI, OP_AUIPC:
        enc_word = {imm[31:12], rd, opcode};
      OP_JAL:
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default:
        legal = 1'b0;
    endcase
  end

  // in_ready ignores out_ready on purpose: a full buffer never takes a word
  // even when the head leaves in the same cycle.
  assign in_ready  = (count < 2'd2) && !flush && !rst;
  assign out_valid = (count != 2'd0) && !rst;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready;

  assign instruction = rst ? 32'h0 : inst_mem[rd_ptr];
  assign addr        = rst ? BASE_ADDR : addr_mem[rd_ptr];
  assign err         = err_q && !rst;
  assign err_cnt     = rst ? 8'h00 : err_cnt_q;

  // Storage array, no reset needed: entries are only read once count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= enc_word;
      addr_mem[wr_ptr] <= pc;
    end
  end

  // Pointers, occupancy, address counter and error state. Flush shares the
  // reset path so it wins over any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      pc        <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
        pc     <= pc + 32'd4;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (accept && !legal) begin
        err_q <= 1'b1;
        if (err_cnt_q != 8'hFF)
          err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
//   Self-checking bench for instr_encoder. Expected words come from a
//   shift-and-mask model of the RV32I formats (or known-answer constants) and
//   are queued when a field set is accepted; a monitor pops and compares each
//   word the DUT hands over. A second instance exercises address wrap-around.
module tb_instr_encoder;

  localparam logic [31:0] BASE1 = 32'h0000_0000;
  localparam logic [31:0] BASE2 = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, err;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm, instruction, addr;
  logic [7:0]  err_cnt;

  logic        flush2, in_valid2, in_ready2, out_valid2, out_ready2, err2;
  logic [31:0] instruction2, addr2;
  logic [7:0]  err_cnt2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  exp_t        sbq[$];
  exp_t        monExp;
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] modelAddr;
  int          modelErrCnt;
  bit          modelErr;
  int          readyMode = 0;

  instr_encoder #(.BASE_ADDR(BASE1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .instruction(instruction), .addr(addr), .err(err), .err_cnt(err_cnt)
  );

  instr_encoder #(.BASE_ADDR(BASE2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .out_valid(out_valid2), .out_ready(out_ready2),
    .instruction(instruction2), .addr(addr2), .err(err2), .err_cnt(err_cnt2)
  );

  // Reference encoder: each field is shifted to its bit position and OR-ed in.
  function automatic logic [31:0] refEncode(input logic [6:0] op, input logic [4:0] rdV,
                                            input logic [2:0] f3, input logic [4:0] rs1V,
                                            input logic [4:0] rs2V, input logic [6:0] f7,
                                            input logic [31:0] im, output bit legal);
    logic [31:0] o, d, f3w, s1, s2, f7w, res;
    o   = 32'(op);
    d   = 32'(rdV) << 7;
    f3w = 32'(f3) << 12;
    s1  = 32'(rs1V) << 15;
    s2  = 32'(rs2V) << 20;
    f7w = 32'(f7) << 25;
    legal = 1'b1;
    res = 32'h0;
    case (op)
      7'b0110011: res = f7w | s2 | s1 | f3w | d | o;
      7'b0000011, 7'b1100111, 7'b1110011:
        res = ((im & 32'hFFF) << 20) | s1 | f3w | d | o;
      7'b0010011:
        if (f3 == 3'd1 || f3 == 3'd5) res = f7w | ((im & 32'h1F) << 20) | s1 | f3w | d | o;
        else                          res = ((im & 32'hFFF) << 20) | s1 | f3w | d | o;
      7'b0100011:
        res = (((im >> 5) & 32'h7F) << 25) | s2 | s1 | f3w | ((im & 32'h1F) << 7) | o;
      7'b1100011:
        res = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | s2 | s1 | f3w |
              (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | o;
      7'b0110111, 7'b0010111:
        res = (im & 32'hFFFF_F000) | d | o;
      7'b1101111:
        res = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
              (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | d | o;
      default: legal = 1'b0;
    endcase
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  // Offers one field set and waits (bounded) for acceptance; the expected
  // entry is queued only once the handshake has completed.
  task automatic applyStimulus(input logic [6:0] op, input logic [4:0] rdV, input logic [2:0] f3,
                               input logic [4:0] rs1V, input logic [4:0] rs2V, input logic [6:0] f7,
                               input logic [31:0] immV, input bit useKnown, input logic [31:0] known);
    bit          accepted = 1'b0;
    bit          legal;
    logic [31:0] w;
    exp_t        e;
    opcode = op; rd = rdV; funct3 = f3; rs1 = rs1V; rs2 = rs2V; funct7 = f7; imm = immV;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      reportTimeout("accept");
    end else begin
      w = refEncode(op, rdV, f3, rs1V, rs2V, f7, immV, legal);
      if (legal) begin
        e.instr = useKnown ? known : w;
        e.addr  = modelAddr;
        sbq.push_back(e);
        modelAddr = modelAddr + 32'd4;
      end else begin
        modelErr = 1'b1;
        if (modelErrCnt < 255) modelErrCnt++;
      end
    end
  endtask

  task automatic applyFlush(input bit withPush);
    in_valid = withPush;
    flush = 1'b1;
    sbq.delete();
    modelAddr = BASE1;
    modelErrCnt = 0;
    modelErr = 1'b0;
    @(negedge clk);
    checkOutput("flush_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (sbq.size() == 0) done = 1'b1;
    end
    if (!done) reportTimeout("drain");
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("drained_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
  endtask

  // Consumer side: out_ready policy changes just after each rising edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every completed output handshake must match the queue head.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_output: got 0x%08h@0x%08h expected none", instruction, addr);
      end else begin
        monExp = sbq.pop_front();
        checkOutput("instruction", instruction, monExp.instr);
        checkOutput("addr", addr, monExp.addr);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [6:0] legalOps [10] = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011,
                                7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    opcode = '0; rd = '0; funct3 = '0; rs1 = '0; rs2 = '0; funct7 = '0; imm = '0;
    flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;
    modelAddr = BASE1; modelErrCnt = 0; modelErr = 1'b0;

    // Reset state and first cycle afterwards
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'h0);
    checkOutput("reset_instruction", instruction, 32'h0);
    checkOutput("reset_addr", addr, BASE1);
    checkOutput("reset_err", 32'(err), 32'h0);
    checkOutput("reset_err_cnt", 32'(err_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_after_reset", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;

    // Known-answer words at consecutive addresses
    readyMode = 1;
    applyStimulus(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 1'b1, 32'h00500093);
    applyStimulus(7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1'b1, 32'h002081B3);
    applyStimulus(7'b0100011, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8, 1'b1, 32'h0020A423);
    applyStimulus(7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd16, 1'b1, 32'h00208863);
    applyStimulus(7'b0110111, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000, 1'b1, 32'h123452B7);
    applyStimulus(7'b0010011, 5'd1, 3'd5, 5'd1, 5'd0, 7'b0100000, 32'd3, 1'b1, 32'h4030D093);
    waitDrain();

    // Backpressure: two accepted, third stalls, head held, then in-order drain
    readyMode = 0;
    applyStimulus(7'b0010011, 5'd4, 3'd0, 5'd0, 5'd0, 7'd0, 32'd11, 1'b0, 32'h0);
    applyStimulus(7'b0010011, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'd22, 1'b0, 32'h0);
    fork
      applyStimulus(7'b0010011, 5'd6, 3'd0, 5'd0, 5'd0, 7'd0, 32'd33, 1'b0, 32'h0);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          checkOutput("full_in_ready", 32'(in_ready), 32'h0);
          checkOutput("held_out_valid", 32'(out_valid), 32'h1);
          checkOutput("held_instruction", instruction, sbq[0].instr);
          checkOutput("held_addr", addr, sbq[0].addr);
        end
        @(posedge clk);
        #1;
        readyMode = 1;
      end
    join
    waitDrain();

    // Illegal opcodes between legal words
    applyFlush(1'b0);
    applyStimulus(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 1'b0, 32'h0);
    applyStimulus(7'b0000000, 5'd7, 3'd1, 5'd2, 5'd3, 7'd4, 32'hDEAD, 1'b0, 32'h0);
    applyStimulus(7'b0000000, 5'd8, 3'd2, 5'd3, 5'd4, 7'd5, 32'hBEEF, 1'b0, 32'h0);
    applyStimulus(7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1'b0, 32'h0);
    waitDrain();
    checkOutput("err_after_illegal", 32'(err), 32'h1);
    checkOutput("err_cnt_after_illegal", 32'(err_cnt), 32'd2);

    // Flush with two buffered words and a concurrent push
    readyMode = 0;
    applyStimulus(7'b0010011, 5'd9, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1, 1'b0, 32'h0);
    applyStimulus(7'b0010011, 5'd10, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2, 1'b0, 32'h0);
    opcode = 7'b0110011; rd = 5'd11;
    applyFlush(1'b1);
    @(negedge clk);
    checkOutput("post_flush_out_valid", 32'(out_valid), 32'h0);
    checkOutput("post_flush_err_cnt", 32'(err_cnt), 32'h0);
    checkOutput("post_flush_err", 32'(err), 32'h0);
    @(posedge clk);
    #1;
    readyMode = 1;
    applyStimulus(7'b0010011, 5'd12, 3'd0, 5'd0, 5'd0, 7'd0, 32'd7, 1'b0, 32'h0);
    waitDrain();

    // Address wrap on the second instance
    opcode = 7'b0010011; rd = 5'd1; funct3 = 3'd0; rs1 = 5'd0; rs2 = 5'd0; funct7 = 7'd0; imm = 32'd5;
    in_valid2 = 1'b1;
    @(negedge clk);
    checkOutput("wrap_in_ready_0", 32'(in_ready2), 32'h1);
    @(posedge clk);
    #1;
    opcode = 7'b0110011; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = 32'd0;
    @(negedge clk);
    checkOutput("wrap_in_ready_1", 32'(in_ready2), 32'h1);
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    out_ready2 = 1'b1;
    @(negedge clk);
    checkOutput("wrap_valid_0", 32'(out_valid2), 32'h1);
    checkOutput("wrap_addr_0", addr2, 32'hFFFF_FFFC);
    checkOutput("wrap_instr_0", instruction2, 32'h00500093);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("wrap_valid_1", 32'(out_valid2), 32'h1);
    checkOutput("wrap_addr_1", addr2, 32'h0000_0000);
    checkOutput("wrap_instr_1", instruction2, 32'h002081B3);
    checkOutput("wrap_err", 32'(err2), 32'h0);
    checkOutput("wrap_err_cnt", 32'(err_cnt2), 32'h0);
    @(posedge clk);
    #1;
    out_ready2 = 1'b0;

    // Randomized traffic with random backpressure, illegal opcodes and flushes
    readyMode = 2;
    for (int n = 0; n < 80; n++) begin
      logic [6:0] op;
      if ($urandom_range(0, 5) == 0) op = 7'($urandom);
      else                           op = legalOps[$urandom_range(0, 9)];
      if ($urandom_range(0, 24) == 0) applyFlush(1'($urandom_range(0, 1)));
      applyStimulus(op, 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
                    7'($urandom), $urandom, 1'b0, 32'h0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    readyMode = 1;
    waitDrain();
    checkOutput("final_err", 32'(err), 32'(modelErr));
    checkOutput("final_err_cnt", 32'(err_cnt), 32'(modelErrCnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
